dmem_arb: RTL
=============

# dmem_arb

Data-memory port arbiter for the diad core. Shares the single-port synchronous data memory between the pipeline's memory-access stage (MA) and an auxiliary requester (debug/DMA loader). The pipeline has priority, and a starvation counter guarantees the auxiliary port forward progress. Read data returns one cycle after issue and is routed back to the issuing requester.

## Interface
Parameters:
- ADDR_W, 12, data-memory word address width
- DATA_W, 24, data word width
- MAX_WAIT, 4, consecutive denied auxiliary cycles before auxiliary is forced through (1..15)

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  synchronous active-high reset
- iw_pipe_req  in  1  MA stage has a load/store this cycle
- iw_pipe_we  in  1  1 = store
- iw_pipe_addr  in  ADDR_W  pipeline address
- iw_pipe_wdata  in  DATA_W  pipeline store data
- ow_pipe_stall  out  1  pipeline access not issued; MA/MO must hold
- ow_pipe_rvalid  out  1  pipeline load data valid
- ow_pipe_rdata  out  DATA_W  pipeline load data
- iw_aux_req  in  1  auxiliary access request, held until granted
- iw_aux_we  in  1  1 = write
- iw_aux_addr  in  ADDR_W  auxiliary address
- iw_aux_wdata  in  DATA_W  auxiliary write data
- ow_aux_gnt  out  1  auxiliary access issued this cycle
- ow_aux_rvalid  out  1  auxiliary read data valid
- ow_aux_rdata  out  DATA_W  auxiliary read data
- ow_mem_en, ow_mem_we  out  1  memory enable/write enable
- ow_mem_addr  out  ADDR_W;  ow_mem_wdata  out  DATA_W
- iw_mem_rdata  in  DATA_W  memory read data, valid one cycle after a read enable

## Operation
- Grant decision is combinational each cycle from the requests, r_wait and r_state; memory outputs are muxed from the winner.
- r_state in {S_IDLE, S_PIPE_RD, S_AUX_RD}: records which requester issued a read in the previous cycle, for rdata routing. Next state is S_PIPE_RD or S_AUX_RD on a granted read, otherwise S_IDLE. Writes leave it S_IDLE.
- Default priority: pipeline wins when both request.
- r_wait (4 bits) increments each cycle iw_aux_req=1 and ow_aux_gnt=0, and clears when ow_aux_gnt=1 or iw_aux_req=0.
- Forced aux: when r_wait == MAX_WAIT and iw_aux_req=1, auxiliary wins even if iw_pipe_req=1.
- ow_pipe_stall = iw_pipe_req & ~pipe_granted. An idle pipeline never stalls.
- ow_mem_en = 0 when neither requester is granted; ow_mem_addr/ow_mem_wdata then drive 0.
- rdata outputs pass iw_mem_rdata when the matching rvalid is high, else 0.
- Aux grant is one beat: a held iw_aux_req with ow_aux_gnt=1 is accepted, and the requester must change address or drop req next cycle.

## Timing
- Reset values: ow_pipe_stall=0, ow_aux_gnt=0, both rvalid=0, both rdata=0, ow_mem_en=ow_mem_we=0, addr/wdata=0, r_state=S_IDLE, r_wait=0.
- Grant/stall/mem outputs are same-cycle (combinational) relative to requests.
- Read latency is exactly 1 cycle: a read issued at edge N gives rvalid high during cycle N+1.
- Write completes at the issuing edge and produces no rvalid.
- Back-to-back reads are supported each cycle. rvalid for cycle N's read and the grant for cycle N+1 coexist.
- Reset asserted with a read in flight: rvalid is not produced after reset; the in-flight read is dropped.
- During reset, all requests are ignored and no grants are issued.
- Worst-case auxiliary latency without round-robin: MAX_WAIT+1 cycles from req to gnt.

## Configuration
- DMEM_ARB_RR_EN defined: fair round-robin. A 1-bit r_last_owner register is added. On contention, the requester not granted last time wins. r_wait and MAX_WAIT are unused, and r_wait is held at 0.
- Not defined: pipeline priority with the MAX_WAIT starvation override as described above.

## Test plan
- Pipeline-only load at addr 0x005 (mem holds 0x00ABCD): stall=0, mem_en=1 same cycle; next cycle pipe_rvalid=1, pipe_rdata=0x00ABCD, aux_rvalid=0.
- Aux write 0x123456 to 0x010 with pipe idle: aux_gnt=1, mem_we=1 same cycle. A subsequent pipeline load of 0x010 returns 0x123456.
- Pipe and aux both request continuously (MAX_WAIT=4): pipe granted for cycles 0–3, aux granted in cycle 4 with ow_pipe_stall=1 that cycle only, r_wait back to 0.
- Alternating pipe read/aux read every cycle: each rvalid/rdata pair appears one cycle later, on the correct port only.
- Reset asserted the cycle after a pipe read issue: pipe_rvalid stays 0, all outputs at reset values next cycle.
- With DMEM_ARB_RR_EN, continuous contention: grants alternate pipe, aux, pipe, aux; stall is high on every other cycle.

Source files
------------

// File: rtl/dmem_arb.sv
// Data-memory port arbiter: pipeline MA stage vs auxiliary requester, with read-data routing.
// Optional build macro DMEM_ARB_RR_EN selects fair round-robin instead of pipeline priority.
module dmem_arb #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 24,
  parameter int MAX_WAIT = 4
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_pipe_req,
  input  logic              iw_pipe_we,
  input  logic [ADDR_W-1:0] iw_pipe_addr,
  input  logic [DATA_W-1:0] iw_pipe_wdata,
  output logic              ow_pipe_stall,
  output logic              ow_pipe_rvalid,
  output logic [DATA_W-1:0] ow_pipe_rdata,
  input  logic              iw_aux_req,
  input  logic              iw_aux_we,
  input  logic [ADDR_W-1:0] iw_aux_addr,
  input  logic [DATA_W-1:0] iw_aux_wdata,
  output logic              ow_aux_gnt,
  output logic              ow_aux_rvalid,
  output logic [DATA_W-1:0] ow_aux_rdata,
  output logic              ow_mem_en,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic [DATA_W-1:0] iw_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_PIPE_RD, S_AUX_RD} state_e;

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       pipe_gnt, aux_gnt;

`ifdef DMEM_ARB_RR_EN
  logic last_aux_q, last_aux_d;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    pipe_gnt = 1'b0;
    aux_gnt  = 1'b0;
    // Reset suppresses grants even though the request inputs may be active.
    if (!iw_rst) begin
`ifdef DMEM_ARB_RR_EN
      aux_gnt = iw_aux_req && (!iw_pipe_req || !last_aux_q);
`else
      aux_gnt = iw_aux_req && (!iw_pipe_req || (wait_q == 4'(MAX_WAIT)));
`endif
      pipe_gnt = iw_pipe_req && !aux_gnt;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (pipe_gnt && !iw_pipe_we) state_d = S_PIPE_RD;
    if (aux_gnt && !iw_aux_we)   state_d = S_AUX_RD;

`ifdef DMEM_ARB_RR_EN
    wait_d     = 4'd0;
    last_aux_d = last_aux_q;
    if (aux_gnt)  last_aux_d = 1'b1;
    if (pipe_gnt) last_aux_d = 1'b0;
`else
    wait_d = 4'd0;
    if (iw_aux_req && !aux_gnt) wait_d = wait_q + 4'd1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Reset as if aux owned last, so the pipeline wins the first contention.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) last_aux_q <= 1'b1;
    else        last_aux_q <= last_aux_d;
  end
`endif

  always_comb begin
    ow_pipe_stall  = iw_pipe_req && !pipe_gnt && !iw_rst;
    ow_aux_gnt     = aux_gnt;
    // A read in flight when reset arrives is dropped, so rvalid is gated by reset too.
    ow_pipe_rvalid = !iw_rst && (state_q == S_PIPE_RD);
    ow_aux_rvalid  = !iw_rst && (state_q == S_AUX_RD);
    ow_pipe_rdata  = ow_pipe_rvalid ? iw_mem_rdata : '0;
    ow_aux_rdata   = ow_aux_rvalid  ? iw_mem_rdata : '0;

    ow_mem_en    = 1'b0;
    ow_mem_we    = 1'b0;
    ow_mem_addr  = '0;
    ow_mem_wdata = '0;
    if (pipe_gnt) begin
      ow_mem_en    = 1'b1;
      ow_mem_we    = iw_pipe_we;
      ow_mem_addr  = iw_pipe_addr;
      ow_mem_wdata = iw_pipe_wdata;
    end else if (aux_gnt) begin
      ow_mem_en    = 1'b1;
      ow_mem_we    = iw_aux_we;
      ow_mem_addr  = iw_aux_addr;
      ow_mem_wdata = iw_aux_wdata;
    end
  end

endmodule
